// File: rtl/aes_ctrl_8.sv
// aes_ctrl_8: sequencer for a byte-serial AES-128 datapath.
// Takes 16 plaintext bytes over valid/ready, then steps rounds 1..NR and flags the ciphertext bytes.
module aes_ctrl_8 #(
  parameter int          NR        = 10,
  parameter logic [31:0] C3_LUT    = 32'h0000_0000,
  parameter logic [31:0] MC_LUT    = 32'h0103_0709,
  parameter logic [1:0]  PLD_PHASE = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       pld,
  output logic [1:0] c3,
  output logic [7:0] mc_en,
  output logic       key_load,
  output logic       rk_step,
  output logic       rk_last,
  output logic [3:0] round,
  output logic [3:0] byte_cnt,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;
  logic [1:0] r_state;
  logic [3:0] r_round;
  logic [3:0] r_cnt;
  logic       r_err;
  logic       w_idle;
  logic       w_load;
  logic       w_run;
  logic       w_last;
  logic       w_mix;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (start && in_valid) begin
          r_state <= S_LOAD;
          r_cnt   <= 4'd1;
        end
        S_LOAD: if (!in_valid) begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          r_err   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= S_RUN;
            r_round <= 4'd1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= w_last ? S_FIN : S_RUN;
            r_round <= w_last ? 4'd0 : r_round + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // Everything except the IDLE handshake decodes from registered state.
  always_comb begin
    w_idle    = r_state == S_IDLE;
    w_load    = r_state == S_LOAD;
    w_run     = r_state == S_RUN;
    w_last    = w_run && (r_round == 4'(NR));
    w_mix     = w_run && !w_last;
    in_ready  = w_idle ? start : w_load;
    key_load  = w_idle && start && in_valid;
    busy      = w_load || w_run;
    done      = r_state == S_FIN;
    err       = r_err;
    c3        = done ? 2'd0 : C3_LUT[{r_cnt, 1'b0} +: 2];
    mc_en     = w_mix ? MC_LUT[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;
    pld       = w_mix && (r_cnt[1:0] == PLD_PHASE);
    rk_step   = (w_load || w_mix) && (r_cnt == 4'd15);
    rk_last   = w_last;
    out_valid = w_last;
    round     = r_round;
    byte_cnt  = r_cnt;
  end
endmodule

// File: tb/tb_aes_ctrl_8.sv
// tb_aes_ctrl_8: randomized bench for aes_ctrl_8 against a block-timeline reference model.
// The model tracks only the cycle offset since byte 0 was accepted and derives every output from it.
module tb_aes_ctrl_8;
  localparam logic [31:0] C3_LUT = 32'h0000_0000;
  localparam logic [31:0] MC_LUT = 32'h0103_0709;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, pld, key_load, rk_step, rk_last, out_valid, busy, done, err;
  logic [1:0] c3;
  logic [7:0] mc_en;
  logic [3:0] round, byte_cnt;
  int checks = 0;
  int errors = 0;
  int t = -1;
  bit err_pend = 1'b0;
  int cyc = 0;
  int n_rk, n_pld, n_ov, acc_cyc, ov_first;

  aes_ctrl_8 dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .pld(pld), .c3(c3), .mc_en(mc_en), .key_load(key_load), .rk_step(rk_step),
    .rk_last(rk_last), .round(round), .byte_cnt(byte_cnt), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h exp %0h", tag, t, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit ld, rn, lst, mix;
    int r, b;
    ld  = t >= 1 && t <= 15;
    rn  = t >= 16 && t < 176;
    r   = rn ? t / 16 : 0;
    b   = (ld || rn) ? t % 16 : 0;
    lst = rn && r == 10;
    mix = rn && !lst;
    chk("in_ready", in_ready, t < 0 ? start : ld);
    chk("key_load", key_load, t < 0 && start && in_valid);
    chk("busy", busy, ld || rn);
    chk("done", done, t == 176);
    chk("err", err, err_pend);
    chk("round", round, r);
    chk("byte_cnt", byte_cnt, b);
    chk("c3", c3, t == 176 ? 0 : (C3_LUT >> (2 * b)) & 3);
    chk("mc_en", mc_en, mix ? (MC_LUT >> (8 * (b % 4))) & 8'hff : 0);
    chk("pld", pld, mix && b % 4 == 3);
    chk("rk_step", rk_step, (ld || mix) && b == 15);
    chk("rk_last", rk_last, lst);
    chk("out_valid", out_valid, lst);
    n_rk  += int'(rk_step);
    n_pld += int'(pld);
    n_ov  += int'(out_valid);
    if (out_valid && ov_first < 0) ov_first = cyc;
  endtask

  task automatic step(input bit s, input bit v);
    start    = s;
    in_valid = v;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    err_pend = 1'b0;
    if (t < 0) begin
      if (s && v) begin
        t = 1;
        acc_cyc = cyc;
      end
    end else if (t <= 15 && !v) begin
      t = -1;
      err_pend = 1'b1;
    end else t = (t == 176) ? -1 : t + 1;
    cyc++;
    #1;
  endtask

  task automatic block(input int abort_at, input int rst_at, input bit fin_start);
    bit s, v;
    int guard;
    n_rk = 0; n_pld = 0; n_ov = 0; ov_first = -1;
    step(1'b1, 1'b1);
    guard = 0;
    while (t >= 0 && guard < 400) begin
      guard++;
      s = 1'($urandom);
      v = 1'($urandom);
      if (t <= 15) v = (t != abort_at);
      if (t == 176 && fin_start) begin s = 1'b1; v = 1'b1; end
      if (t == rst_at) begin
        start = 1'b0; in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_round", round, 0);
        chk("rst_cnt", byte_cnt, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_mc", mc_en, 0);
        chk("rst_last", rk_last, 0);
        chk("rst_c3", c3, C3_LUT & 3);
        @(posedge clk);
        #1;
        rst = 1'b0; t = -1; err_pend = 1'b0; cyc++;
        return;
      end
      step(s, v);
    end
    chk("block_ends", guard < 400, 1);
    if (abort_at == 0) begin
      chk("n_rk_step", n_rk, 10);
      chk("n_pld", n_pld, 36);
      chk("n_out_valid", n_ov, 16);
      chk("ct_offset", ov_first - acc_cyc, 160);
    end else begin
      chk("abort_rk", n_rk, 0);
      step(1'b0, 1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    block(0, 0, 1'b1);
    block(0, 0, 1'b0);
    block(7, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) step(1'($urandom), 1'b0);
      block((i % 2) ? int'($urandom_range(1, 14)) : 0, 0, 1'($urandom));
    end
    block(0, 70, 1'b0);
    block(0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
